c157x_track_xfer: RTL

C157X_TRACK_XFER -- requirements
Module: c157x_track_xfer

---
 rtl/c157x_track_xfer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/c157x_track_xfer.sv
// c157x_track_xfer -- moves whole MFM track images between an SD-card disk
// image and the drive's track buffer.
//
// One track buffer holds a single half-track slot. When the head moves to a
// different slot the buffer is written back (if the head logic modified it)
// and the new slot is read in. A modified buffer that sits idle for
// FLUSH_DLY cycles is written back even without a head move, so data reaches
// the card when the host stops stepping.
//
// Ports:
//   sd_clk        clock, all logic on the rising edge
//   reset         synchronous, active-high reset
//   enable        drive powered/selected; low blocks new transfers
//   img_mounted   one-cycle pulse when a new image is inserted
//   img_ds        image is dual sided
//   img_readonly  image is write-protected
//   htrack[6:0]   requested half-track (valid below HTRACKS)
//   side          requested head side
//   sd_update     one-cycle pulse: head logic modified a buffer byte
//   sd_ack        host acknowledge, high for the whole transfer
//   sd_lba[31:0]  first block of the current transfer
//   sd_blk_cnt    block count minus one (constant)
//   sd_rd/sd_wr   read / write request to the host
//   busy          transfer in progress (plus one trailing cycle)
//   loaded        buffer holds a valid track
module c157x_track_xfer #(
  parameter int TRACK_BLKS = 26,
  parameter int HTRACKS    = 84,
  parameter int FLUSH_DLY  = 1_000_000
) (
  input  logic        sd_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        img_mounted,
  input  logic        img_ds,
  input  logic        img_readonly,
  input  logic [6:0]  htrack,
  input  logic        side,
  input  logic        sd_update,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic [5:0]  sd_blk_cnt,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        busy,
  output logic        loaded
);

  // Flush counter is at least 20 bits wide, wider if FLUSH_DLY needs it.
  localparam int FW = ($clog2(FLUSH_DLY + 1) > 20) ? $clog2(FLUSH_DLY + 1) : 20;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t         state_q;
  logic [7:0]     cur_slot_q;
  logic [7:0]     lat_slot_q;
  logic           loaded_q;
  logic           dirty_q;
  logic           wr_upd_q;     // buffer modified while write-back in flight
  logic [FW-1:0]  flush_cnt_q;
  logic [31:0]    sd_lba_q;
  logic           sd_rd_q;
  logic           sd_wr_q;
  logic           busy_q;

  logic           eside;
  logic [7:0]     target_slot;
  logic           req_valid;
  logic           flush_expired;
  logic           want_wr;
  logic           want_rd;
  logic           rd_in_flight;
  logic           upd_ok;

  function automatic logic [31:0] slot_lba(input logic [7:0] s);
    return 32'(s) * 32'(TRACK_BLKS);
  endfunction

  always_comb begin
    eside         = side & img_ds;
    target_slot   = {1'b0, htrack} + (eside ? 8'(HTRACKS) : 8'd0);
    req_valid     = ({1'b0, htrack} < 8'(HTRACKS));
    flush_expired = (flush_cnt_q == '0);
    // Write-back is checked first so a dirty buffer is never overwritten.
    want_wr       = enable & req_valid & dirty_q &
                    ((target_slot != cur_slot_q) | flush_expired);
    want_rd       = enable & req_valid & ~dirty_q &
                    (~loaded_q | (target_slot != cur_slot_q));
    rd_in_flight  = (state_q == RD_REQ) | (state_q == RD_WAIT);
    // Edits landing while a read overwrites the buffer are meaningless.
    upd_ok        = sd_update & loaded_q & ~img_readonly & ~rd_in_flight;
  end

  always_ff @(posedge sd_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_slot_q  <= '0;
      lat_slot_q  <= '0;
      loaded_q    <= 1'b0;
      dirty_q     <= 1'b0;
      wr_upd_q    <= 1'b0;
      flush_cnt_q <= FW'(FLUSH_DLY);
      sd_lba_q    <= '0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (sd_update)
        flush_cnt_q <= FW'(FLUSH_DLY);
      else if (dirty_q && state_q == IDLE && !flush_expired)
        flush_cnt_q <= flush_cnt_q - 1'b1;

      // Stays high in every active state and for the first IDLE cycle.
      busy_q <= (state_q != IDLE);

      if (upd_ok)
        dirty_q <= 1'b1;
      if (upd_ok && (state_q == WR_REQ || state_q == WR_WAIT))
        wr_upd_q <= 1'b1;

      if (img_mounted) begin
        // New medium: buffer contents are stale, drop them without write-back.
        state_q  <= IDLE;
        sd_rd_q  <= 1'b0;
        sd_wr_q  <= 1'b0;
        loaded_q <= 1'b0;
        dirty_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (want_wr) begin
              state_q  <= WR_REQ;
              sd_wr_q  <= 1'b1;
              sd_lba_q <= slot_lba(cur_slot_q);
              wr_upd_q <= 1'b0;
              busy_q   <= 1'b1;
            end else if (want_rd) begin
              state_q    <= RD_REQ;
              sd_rd_q    <= 1'b1;
              sd_lba_q   <= slot_lba(target_slot);
              lat_slot_q <= target_slot;
              busy_q     <= 1'b1;
            end
          end
          RD_REQ: begin
            if (sd_ack) begin
              sd_rd_q <= 1'b0;
              state_q <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            if (!sd_ack) begin
              state_q    <= IDLE;
              cur_slot_q <= lat_slot_q;
              loaded_q   <= 1'b1;
              dirty_q    <= 1'b0;
            end
          end
          WR_REQ: begin
            if (sd_ack) begin
              sd_wr_q <= 1'b0;
              state_q <= WR_WAIT;
            end
          end
          WR_WAIT: begin
            if (!sd_ack) begin
              state_q <= IDLE;
              dirty_q <= wr_upd_q | upd_ok;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sd_lba     = sd_lba_q;
  assign sd_blk_cnt = 6'(TRACK_BLKS - 1);
  assign sd_rd      = sd_rd_q;
  assign sd_wr      = sd_wr_q;
  assign busy       = busy_q;
  assign loaded     = loaded_q;

endmodule
